// File: rtl/reg_bank_sb_pkg.sv
// Shared constants and types for the register bank and its pending-write scoreboard.
package reg_bank_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DEF_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_bank_sb_if.sv
// Issue, write-back and read-port bundle between decode/write-back (master) and the bank (slave).
interface reg_bank_sb_if
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              issue_valid;
  reg_addr_t         issue_dest;
  logic              issue_ready;
  logic              wb_valid;
  reg_addr_t         wb_addr;
  logic [DATA_W-1:0] wb_data;
  reg_addr_t         rs_addr;
  reg_addr_t         rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              err_underflow;

  modport master (
    output issue_valid, issue_dest, wb_valid, wb_addr, wb_data, rs_addr, rt_addr,
    input  issue_ready, rs_data, rt_data, rs_busy, rt_busy, err_underflow
  );

  modport slave (
    input  issue_valid, issue_dest, wb_valid, wb_addr, wb_data, rs_addr, rt_addr,
    output issue_ready, rs_data, rt_data, rs_busy, rt_busy, err_underflow
  );

endinterface

// File: rtl/reg_bank_sb_counter.sv
// Saturating up/down pending-write counter for one register.
// fwd_en makes 'nonzero' report the count net of a same-cycle retire, so a
// reader is not stalled by the write that is completing this cycle.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic fwd_en,
  input  logic inc,
  input  logic dec,
  output logic at_max,
  output logic nonzero,
  output logic underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc/dec cancel; never wraps in either direction.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max    = (cnt_q == CNT_MAX);
  assign nonzero   = ((cnt_q - CNT_W'(fwd_en && dec)) != '0);
  assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/reg_bank_sb.sv
// 32-entry register bank (2 comb reads, 1 sync write) with per-register
// pending-write scoreboard for RAW hazard detection.
// Optional same-cycle write-back forwarding: define REG_BANK_BYPASS_EN.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 2
) (
  input logic          clk,
  input logic          rst,
  reg_bank_sb_if.slave bus
);

`ifdef REG_BANK_BYPASS_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  logic [DATA_W-1:0]   bank_q [NUM_REGS];
  logic [DATA_W-1:0]   bank_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v, dec_v, at_max_v, nonzero_v, uflow_v;
  logic                err_q, err_d;
  logic                issue_ready;

  // Register 0 has no counter: never busy, never saturates, never underflows.
  assign at_max_v[0]  = 1'b0;
  assign nonzero_v[0] = 1'b0;
  assign uflow_v[0]   = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .fwd_en   (FWD_EN),
        .inc      (inc_v[r]),
        .dec      (dec_v[r]),
        .at_max   (at_max_v[r]),
        .nonzero  (nonzero_v[r]),
        .underflow(uflow_v[r])
      );
    end
  endgenerate

  // A saturated register only takes a new issue when a retire frees a slot this cycle.
  assign issue_ready = (bus.issue_dest == REG_ZERO) || !at_max_v[bus.issue_dest] ||
                       (bus.wb_valid && (bus.wb_addr == bus.issue_dest));
  assign bus.issue_ready = issue_ready;

  // One-hot issue/retire decode per register (entry 0 never counts).
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc_v[i] = bus.issue_valid && issue_ready && (bus.issue_dest == reg_addr_t'(i));
      dec_v[i] = bus.wb_valid && (bus.wb_addr == reg_addr_t'(i));
    end
  end

  // Bank next-state: write-back update, entry 0 pinned to zero.
  always_comb begin
    bank_d = bank_q;
    if (bus.wb_valid && (bus.wb_addr != REG_ZERO)) begin
      bank_d[bus.wb_addr] = bus.wb_data;
    end
    bank_d[0] = '0;
  end

  // Bank storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      bank_q <= bank_d;
    end
  end

  // Sticky underflow flag; cleared only by reset.
  always_comb begin
    err_d = err_q | (|uflow_v);
  end

  // Underflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_underflow = err_q;

  // Read port A: stored value, optionally forwarded from the retiring write.
  always_comb begin
    bus.rs_data = bank_q[bus.rs_addr];
    if (FWD_EN && bus.wb_valid && (bus.wb_addr == bus.rs_addr) && (bus.rs_addr != REG_ZERO)) begin
      bus.rs_data = bus.wb_data;
    end
    bus.rs_busy = nonzero_v[bus.rs_addr];
  end

  // Read port B: same as port A.
  always_comb begin
    bus.rt_data = bank_q[bus.rt_addr];
    if (FWD_EN && bus.wb_valid && (bus.wb_addr == bus.rt_addr) && (bus.rt_addr != REG_ZERO)) begin
      bus.rt_data = bus.wb_data;
    end
    bus.rt_busy = nonzero_v[bus.rt_addr];
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench for reg_bank_sb: expectations are queued when a cycle is
// driven and compared against the DUT outputs at the following falling edge.
module tb_reg_bank_sb;
  import reg_bank_pkg::*;

  localparam int SEL_RS = 0, SEL_RT = 1, SEL_RSB = 2, SEL_RTB = 3, SEL_RDY = 4, SEL_ERR = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bank_sb_if #(.DATA_W(32)) bus ();

  reg_bank_sb #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_bank[32];
  int          m_cnt[32];
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RS:  return bus.rs_data;
      SEL_RT:  return bus.rt_data;
      SEL_RSB: return {31'd0, bus.rs_busy};
      SEL_RTB: return {31'd0, bus.rt_busy};
      SEL_RDY: return {31'd0, bus.issue_ready};
      default: return {31'd0, bus.err_underflow};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_bank[i] = '0;
      m_cnt[i]  = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] exp_data(input int a, input bit wv, input int wa, input logic [31:0] wd);
`ifdef REG_BANK_BYPASS_EN
    if (wv && (wa == a) && (a != 0)) return wd;
`endif
    return m_bank[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit wv, input int wa);
    int d;
    d = 0;
    if (a == 0) return 1'b0;
`ifdef REG_BANK_BYPASS_EN
    if (wv && (wa == a)) d = 1;
`endif
    return (((m_cnt[a] - d) & 3) != 0);
  endfunction

  // Drive one cycle, queue model expectations, compare at negedge, advance model at posedge.
  task automatic cycle(input bit iv, input int idest, input bit wv, input int wa,
                       input logic [31:0] wd, input int rsa, input int rta);
    logic rdy;
    bit   inc, dec;
    bus.issue_valid = iv;
    bus.issue_dest  = 5'(idest);
    bus.wb_valid    = wv;
    bus.wb_addr     = 5'(wa);
    bus.wb_data     = wd;
    bus.rs_addr     = 5'(rsa);
    bus.rt_addr     = 5'(rta);
    rdy = (idest == 0) || (m_cnt[idest] != 3) || (wv && (wa == idest));
    push("issue_ready", SEL_RDY, {31'd0, rdy});
    push("rs_data", SEL_RS, exp_data(rsa, wv, wa, wd));
    push("rt_data", SEL_RT, exp_data(rta, wv, wa, wd));
    push("rs_busy", SEL_RSB, {31'd0, exp_busy(rsa, wv, wa)});
    push("rt_busy", SEL_RTB, {31'd0, exp_busy(rta, wv, wa)});
    push("err_underflow", SEL_ERR, {31'd0, m_err});
    @(negedge clk);
    drain();
    @(posedge clk);
    inc = iv && rdy && (idest != 0);
    dec = wv && (wa != 0);
    if (dec && (m_cnt[wa] == 0)) m_err = 1'b1;
    if (!(inc && dec && (idest == wa))) begin
      if (inc) m_cnt[idest]++;
      if (dec && (m_cnt[wa] > 0)) m_cnt[wa]--;
    end
    if (dec) m_bank[wa] = wd;
    #1;
  endtask

  task automatic idle(input int rsa, input int rta);
    cycle(1'b0, 0, 1'b0, 0, 32'h0, rsa, rta);
  endtask

  initial begin
    rst             = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_dest  = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.rs_addr     = '0;
    bus.rt_addr     = '0;
    model_reset();

    // Reset state
    #3;
    push("rst_rs_data", SEL_RS, 32'h0);
    push("rst_rs_busy", SEL_RSB, 32'h0);
    push("rst_ready", SEL_RDY, 32'h1);
    push("rst_err", SEL_ERR, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Mid-stream reset after writes to r5 (the unissued write also trips underflow)
    cycle(1'b0, 0, 1'b1, 5, 32'h5555_0005, 0, 0);
    push("r5_written", SEL_RS, 32'h5555_0005);
    cycle(1'b1, 5, 1'b0, 0, 32'h0, 5, 5);
    bus.issue_valid = 1'b0;
    bus.issue_dest  = 5'd5;
    bus.wb_valid    = 1'b1;
    bus.wb_addr     = 5'd5;
    bus.wb_data     = 32'hFFFF_FFFF;
    bus.rs_addr     = 5'd5;
    rst             = 1'b1;
    #1;
    push("midrst_rs_data", SEL_RS, 32'h0);
    push("midrst_rs_busy", SEL_RSB, 32'h0);
    push("midrst_ready", SEL_RDY, 32'h1);
    push("midrst_err", SEL_ERR, 32'h0);
    drain();
    @(posedge clk);
    #1;
    push("midrst_wb_lost", SEL_RS, 32'h0);
    drain();
    @(negedge clk);
    bus.wb_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Write/read, r0 ignores writes
    cycle(1'b1, 7, 1'b0, 0, 32'h0, 0, 0);
    cycle(1'b0, 0, 1'b1, 7, 32'hDEAD_BEEF, 0, 0);
    push("r7_read", SEL_RT, 32'hDEAD_BEEF);
    cycle(1'b0, 0, 1'b1, 0, 32'h0000_1234, 0, 7);
    push("r0_read", SEL_RS, 32'h0);
    push("r0_ready", SEL_RDY, 32'h1);
    cycle(1'b1, 0, 1'b0, 0, 32'h0, 0, 7);
    push("r0_never_busy", SEL_RSB, 32'h0);
    idle(0, 0);

    // Hazard on r3
    push("r3_busy_same_cycle", SEL_RSB, 32'h0);
    cycle(1'b1, 3, 1'b0, 0, 32'h0, 3, 0);
    push("r3_busy", SEL_RSB, 32'h1);
    idle(3, 0);
`ifdef REG_BANK_BYPASS_EN
    push("r3_busy_retire_fwd", SEL_RSB, 32'h0);
`else
    push("r3_busy_retire_raw", SEL_RSB, 32'h1);
`endif
    cycle(1'b0, 0, 1'b1, 3, 32'h55, 3, 0);
    push("r3_busy_cleared", SEL_RSB, 32'h0);
    push("r3_data", SEL_RS, 32'h55);
    idle(3, 0);

    // Saturation on r9
    for (int i = 0; i < 3; i++) begin
      push("r9_ready_fill", SEL_RDY, 32'h1);
      cycle(1'b1, 9, 1'b0, 0, 32'h0, 9, 0);
    end
    push("r9_ready_sat", SEL_RDY, 32'h0);
    cycle(1'b1, 9, 1'b0, 0, 32'h0, 9, 0);
    push("r9_ready_sat_retire", SEL_RDY, 32'h1);
    cycle(1'b1, 9, 1'b1, 9, 32'h99, 9, 0);
    push("r9_still_sat", SEL_RDY, 32'h0);
    push("r9_busy_sat", SEL_RSB, 32'h1);
    push("err_clear_before", SEL_ERR, 32'h0);
    cycle(1'b1, 9, 1'b0, 0, 32'h0, 9, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 9, 32'h900 + i, 9, 9);
    push("r9_drained", SEL_RSB, 32'h0);
    push("r9_last_data", SEL_RS, 32'h902);
    idle(9, 0);

    // Bypass on r4
    cycle(1'b1, 4, 1'b0, 0, 32'h0, 0, 0);
    cycle(1'b1, 4, 1'b1, 4, 32'h1111, 0, 0);
`ifdef REG_BANK_BYPASS_EN
    push("r4_fwd", SEL_RS, 32'hA5A5);
`else
    push("r4_no_fwd", SEL_RS, 32'h1111);
`endif
    cycle(1'b0, 0, 1'b1, 4, 32'hA5A5, 4, 0);
    push("r4_next", SEL_RS, 32'hA5A5);
    idle(4, 0);

    // Underflow on r12: sticky until reset
    push("uflow_before", SEL_ERR, 32'h0);
    cycle(1'b0, 0, 1'b1, 12, 32'hC0C0, 0, 12);
    push("uflow_set", SEL_ERR, 32'h1);
    push("r12_written", SEL_RT, 32'hC0C0);
    idle(0, 12);
    for (int i = 0; i < 3; i++) idle(0, 0);
    push("uflow_held", SEL_ERR, 32'h1);
    idle(0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    push("uflow_rst_clear", SEL_ERR, 32'h0);
    drain();
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Random traffic on a few registers against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
            $urandom_range(0, 5), $urandom, $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
